ram_writer: RTL

//  Write-side controller for the 256x16 RAM; the counterpart of the RAM's clk/read/adr/out read port.

---
 rtl/ram_writer.sv | 110 +++++++++++
 1 files changed

// File: rtl/ram_writer.sv
// Write-side burst controller for the 256x16 RAM: takes a (base, length) command and
// streams valid/ready words into the RAM write port at sequential, wrapping addresses.
module ram_writer #(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 8,
  parameter int LEN_W  = ADR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADR_W-1:0]  base_adr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADR_W-1:0]  wr_adr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADR_W-1:0] ADR_ONE  = {{(ADR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [ADR_W-1:0]   cur_adr_r;
  logic [LEN_W-1:0]   remaining_r;
  logic               accept_s;

  // in_ready is a registered copy of (state == WRITE), so this is a clean handshake
  assign accept_s = in_valid & in_ready;

  // burst FSM with registered RAM-port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cur_adr_r   <= {ADR_W{1'b0}};
      remaining_r <= LEN_ZERO;
      we          <= 1'b0;
      wr_adr      <= {ADR_W{1'b0}};
      wr_data     <= {DATA_W{1'b0}};
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      done        <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            if (length != LEN_ZERO) begin
              cur_adr_r   <= base_adr;
              remaining_r <= length;
              state_r     <= S_WRITE;
              busy        <= 1'b1;
              in_ready    <= 1'b1;
            end else begin
              state_r <= S_DONE;
              done    <= 1'b1;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (accept_s) begin
            we          <= 1'b1;
            wr_adr      <= cur_adr_r;
            wr_data     <= in_data;
            cur_adr_r   <= cur_adr_r + ADR_ONE;
            remaining_r <= remaining_r - LEN_ONE;
          end else begin
            cur_adr_r <= cur_adr_r;
          end
          // abort wins over completion: the last word is still written but done is suppressed
          if (abort) begin
            state_r  <= S_IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b0;
          end else if (accept_s && (remaining_r == LEN_ONE)) begin
            state_r  <= S_DONE;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            done     <= 1'b1;
          end else begin
            state_r <= S_WRITE;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r  <= S_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
